// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the restoring divider
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int NB_BIT_DEFAULT = 8;

  // Iteration counter width; a 1-bit counter still holds nb_bit-1 for nb_bit <= 2.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/subtractor_n.sv
// rtl/subtractor_n.sv - unsigned a - b with borrow out
module subtractor_n #(
  parameter int nb_bit = 9
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);

  logic [nb_bit:0] full;

  assign full     = {1'b0, a_i} - {1'b0, b_i};
  assign diff_o   = full[nb_bit-1:0];
  assign borrow_o = full[nb_bit];

endmodule

// File: rtl/divider_n.sv
// rtl/divider_n.sv - sequential restoring unsigned divider, one quotient bit per clock
module divider_n
  import divider_pkg::*;
#(
  parameter int nb_bit = NB_BIT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [nb_bit-1:0] dividend_i,
  input  logic [nb_bit-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [nb_bit-1:0] quotient_o,
  output logic [nb_bit-1:0] remainder_o,
  output logic              div_by_zero_o
);

  localparam int CW = cnt_width(nb_bit);

  div_state_t        state_q;
  logic [nb_bit:0]   r_q;
  logic [nb_bit:0]   d_q;
  logic [nb_bit-1:0] q_q;
  logic [CW-1:0]     cnt_q;

  logic [nb_bit:0]   t;
  logic [nb_bit:0]   diff;
  logic              borrow;
  logic [nb_bit:0]   r_next;
  logic [nb_bit-1:0] q_next;

  // Trial value: partial remainder shifted left with the next dividend bit.
  assign t = {r_q[nb_bit-1:0], q_q[nb_bit-1]};

  subtractor_n #(
    .nb_bit(nb_bit + 1)
  ) u_sub (
    .a_i     (t),
    .b_i     (d_q),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  assign r_next = borrow ? t : diff;

  if (nb_bit == 1) begin : g_q_one
    assign q_next = ~borrow;
  end else begin : g_q_many
    assign q_next = {q_q[nb_bit-2:0], ~borrow};
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      r_q           <= '0;
      d_q           <= '0;
      q_q           <= '0;
      cnt_q         <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (divisor_i != '0) begin
              r_q     <= '0;
              q_q     <= dividend_i;
              d_q     <= {1'b0, divisor_i};
              cnt_q   <= CW'(nb_bit - 1);
              state_q <= RUN;
            end else begin
              quotient_o    <= '1;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
              state_q       <= DONE;
            end
          end
        end
        RUN: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quotient_o    <= q_next;
            remainder_o   <= r_next[nb_bit-1:0];
            div_by_zero_o <= 1'b0;
            state_q       <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
